// File: rtl/softmax_normalizer.sv
// Softmax normaliser: latches 64 exp values, waits for their sum, forms a
// 32-bit reciprocal by restoring division, then scales four lanes per cycle.
module softmax_normalizer (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [1023:0] exp_values_in,
   input  logic [23:0]   sum_in,
   input  logic          sum_valid,
   output logic [1023:0] prob_out,
   output logic          out_valid,
   output logic          div_zero,
   output logic          busy
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_SUM = 3'd1,
      DIV      = 3'd2,
      MUL      = 3'd3,
      DONE     = 3'd4
   } state_t;

   state_t      state;
   logic [15:0] exp_buf [64];
   logic [15:0] prob_r  [64];
   logic [23:0] sum_r;
   logic [24:0] rem_r;
   logic [31:0] recip;
   logic [4:0]  cnt;

   // Dividend is 2^32: the remainder starts at 1 and shifts in zeros, so
   // sum=1 yields all-ones quotient bits, which is exactly the clamp value.
   logic [24:0] rem_shift;
   logic [24:0] rem_next;
   logic        rem_ge;

   always_comb begin
      rem_shift = rem_r << 1;
      rem_ge    = (rem_shift >= {1'b0, sum_r});
      rem_next  = rem_ge ? (rem_shift - {1'b0, sum_r}) : rem_shift;
   end

   logic [5:0]  lane_idx  [4];
   logic [47:0] prod      [4];
   logic [15:0] lane_prob [4];

   always_comb begin
      for (int j = 0; j < 4; j++) begin
         lane_idx[j]  = {cnt[3:0], 2'(j)};
         prod[j]      = 48'(exp_buf[lane_idx[j]]) * 48'(recip);
         lane_prob[j] = (prod[j][47:32] != 16'd0) ? 16'hFFFF : prod[j][31:16];
      end
   end

   always_comb begin
      prob_out = '0;
      for (int i = 0; i < 64; i++) begin
         prob_out[16*i +: 16] = prob_r[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         div_zero  <= 1'b0;
         busy      <= 1'b0;
         sum_r     <= '0;
         rem_r     <= '0;
         recip     <= '0;
         cnt       <= '0;
         for (int i = 0; i < 64; i++) begin
            exp_buf[i] <= '0;
            prob_r[i]  <= '0;
         end
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  for (int i = 0; i < 64; i++) begin
                     exp_buf[i] <= exp_values_in[16*i +: 16];
                  end
                  busy  <= 1'b1;
                  state <= WAIT_SUM;
               end
            end
            WAIT_SUM: begin
               if (sum_valid) begin
                  sum_r    <= sum_in;
                  div_zero <= 1'b0;
                  if (sum_in == 24'd0) begin
                     div_zero  <= 1'b1;
                     out_valid <= 1'b1;
                     for (int i = 0; i < 64; i++) begin
                        prob_r[i] <= '0;
                     end
                     state <= DONE;
                  end else begin
                     rem_r <= 25'd1;
                     recip <= '0;
                     cnt   <= '0;
                     state <= DIV;
                  end
               end
            end
            DIV: begin
               rem_r <= rem_next;
               recip <= {recip[30:0], rem_ge};
               if (cnt == 5'd31) begin
                  cnt   <= '0;
                  state <= MUL;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
            MUL: begin
               for (int j = 0; j < 4; j++) begin
                  prob_r[lane_idx[j]] <= lane_prob[j];
               end
               if (cnt == 5'd15) begin
                  cnt       <= '0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_softmax_normalizer.sv
// Directed and randomized checks of softmax_normalizer against an arithmetic
// reference of the reciprocal/scale rules.
module tb_softmax_normalizer;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [1023:0] exp_values_in = '0;
   logic [23:0]   sum_in = '0;
   logic          sum_valid = 1'b0;
   logic [1023:0] prob_out;
   logic          out_valid;
   logic          div_zero;
   logic          busy;

   int checks = 0;
   int failures = 0;

   logic [15:0] model_exp [64];
   logic [23:0] model_sum;

   softmax_normalizer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .exp_values_in (exp_values_in),
      .sum_in        (sum_in),
      .sum_valid     (sum_valid),
      .prob_out      (prob_out),
      .out_valid     (out_valid),
      .div_zero      (div_zero),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [15:0] ref_prob(input logic [15:0] e, input logic [23:0] s);
      longint unsigned r;
      longint unsigned p;
      if (s == 24'd0) return 16'h0000;
      r = (64'd1 << 32) / 64'(s);
      if (r > 64'hFFFF_FFFF) r = 64'hFFFF_FFFF;
      p = (64'(e) * r) >> 16;
      return (p > 64'hFFFF) ? 16'hFFFF : 16'(p);
   endfunction

   function automatic logic [1023:0] pack_model();
      logic [1023:0] v;
      for (int i = 0; i < 64; i++) v[16*i +: 16] = model_exp[i];
      return v;
   endfunction

   task automatic fill_model(input logic [15:0] val);
      for (int i = 0; i < 64; i++) model_exp[i] = val;
   endtask

   task automatic start_op();
      @(posedge clk); #1;
      exp_values_in = pack_model();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      exp_values_in = {32{$urandom}};
      chk("busy_after_start", 64'(busy), 64'd1);
   endtask

   task automatic give_sum(input logic [23:0] s, input int gap);
      for (int g = 0; g < gap; g++) begin
         @(posedge clk); #1;
      end
      sum_in = s;
      sum_valid = 1'b1;
      @(posedge clk); #1;
      sum_valid = 1'b0;
      sum_in = 24'(($urandom));
   endtask

   // Called just after the edge that accepted sum_valid; inject_at >= 0
   // drives a stray start and sum_valid that many cycles later.
   task automatic await_result(input string tag, input int inject_at, input bit poke_done);
      int lat = 0;
      int exp_lat;
      exp_lat = (model_sum == 24'd0) ? 0 : 48;
      while (out_valid !== 1'b1 && lat < 100) begin
         start     = (lat == inject_at);
         sum_valid = (lat == inject_at);
         if (lat == inject_at) begin
            exp_values_in = {32{$urandom}};
            sum_in = 24'($urandom_range(1, 5000));
         end
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      sum_valid = 1'b0;
      chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_div_zero"}, 64'(div_zero), (model_sum == 24'd0) ? 64'd1 : 64'd0);
      chk({tag, "_busy_done"}, 64'(busy), 64'd1);
      for (int i = 0; i < 64; i++) begin
         chk($sformatf("%s_prob%0d", tag, i), 64'(prob_out[16*i +: 16]),
             64'(ref_prob(model_exp[i], model_sum)));
      end
      if (poke_done) begin
         start = 1'b1;
         exp_values_in = {32{$urandom}};
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
      chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
      chk({tag, "_hold_prob0"}, 64'(prob_out[15:0]), 64'(ref_prob(model_exp[0], model_sum)));
      chk({tag, "_hold_prob63"}, 64'(prob_out[1023:1008]), 64'(ref_prob(model_exp[63], model_sum)));
   endtask

   initial begin
      int unsigned acc;
      int pulses;

      // Reset values while rst_n is held low
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_div_zero", 64'(div_zero), 64'd0);
      chk("rst_prob_lo", prob_out[63:0], 64'd0);
      chk("rst_prob_hi", prob_out[1023:960], 64'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // sum_valid in IDLE is ignored
      give_sum(24'd0, 1);
      chk("idle_sumvalid_busy", 64'(busy), 64'd0);
      chk("idle_sumvalid_dz", 64'(div_zero), 64'd0);

      // Uniform distribution
      fill_model(16'h0400);
      model_sum = 24'h010000;
      start_op();
      give_sum(model_sum, 2);
      await_result("uniform", -1, 1'b0);

      // Single lane saturation
      fill_model(16'h0000);
      model_exp[5] = 16'h1000;
      model_sum = 24'h001000;
      start_op();
      give_sum(model_sum, 0);
      await_result("saturate", -1, 1'b0);

      // recip = 0x55555555 and clamp at sum=1
      fill_model(16'h0000);
      model_exp[0] = 16'h0001;
      model_sum = 24'd3;
      start_op();
      give_sum(model_sum, 1);
      await_result("sum3", -1, 1'b0);
      model_sum = 24'd1;
      start_op();
      give_sum(model_sum, 3);
      await_result("sum1", -1, 1'b0);

      // Zero sum, plus a start during DONE that must be ignored
      for (int i = 0; i < 64; i++) model_exp[i] = 16'($urandom_range(1, 16'hFFFF));
      model_sum = 24'd0;
      start_op();
      give_sum(model_sum, 1);
      await_result("zero_sum", -1, 1'b1);

      // Randomized data, true sums and arbitrary sums
      for (int n = 0; n < 8; n++) begin
         acc = 0;
         for (int i = 0; i < 64; i++) begin
            model_exp[i] = (n % 2 == 0) ? 16'($urandom_range(0, 16'hFFFF))
                                        : 16'($urandom_range(0, 16'h03FF));
            acc += model_exp[i];
         end
         model_sum = (n < 5) ? 24'(acc) : 24'($urandom_range(1, 24'hFFFFFF));
         if (model_sum == 24'd0) model_sum = 24'd1;
         start_op();
         give_sum(model_sum, $urandom_range(0, 4));
         await_result($sformatf("rand%0d", n), (n == 7) ? 40 : -1, 1'b0);
      end

      // Stray start and sum_valid during DIV
      acc = 0;
      for (int i = 0; i < 64; i++) begin
         model_exp[i] = 16'($urandom_range(0, 16'h7FFF));
         acc += model_exp[i];
      end
      model_sum = 24'(acc);
      start_op();
      give_sum(model_sum, 1);
      await_result("start_in_div", 10, 1'b0);

      // Reset in the middle of MUL aborts without out_valid
      start_op();
      give_sum(model_sum, 0);
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) pulses++;
      end
      rst_n = 1'b0;
      #1;
      chk("midmul_rst_busy", 64'(busy), 64'd0);
      chk("midmul_rst_valid", 64'(out_valid), 64'd0);
      chk("midmul_rst_dz", 64'(div_zero), 64'd0);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("midmul_rst_prob_w%0d", i), prob_out[64*i +: 64], 64'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) pulses++;
      end
      chk("midmul_no_valid", 64'(pulses), 64'd0);
      chk("midmul_idle_busy", 64'(busy), 64'd0);

      // First start after reset works normally
      fill_model(16'h0000);
      model_exp[17] = 16'h1234;
      model_exp[42] = 16'hFFFF;
      model_sum = 24'h012345;
      start_op();
      give_sum(model_sum, 2);
      await_result("after_reset", -1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
